line_mem_ctrl: RTL and testbench
================================

// Module: line_mem_ctrl
// PURPOSE
//  Cache-line burst controller between the cache miss/write-back logic and the word-wide main memory
//  (1-cycle synchronous read, write on clk edge when wr_req). Accepts whole-line read (refill) and write
//  (write-back) requests, adds a programmable access delay, sequences the per-word memory cycles and
//  returns a one-cycle gnt pulse when the line transfer completes.
// PARAMETERS
//  LINE_ADDR_LEN  3   log2(words per line); W = 1<<LINE_ADDR_LEN
//  ADDR_LEN       11  memory word-address width; line address width LA = ADDR_LEN-LINE_ADDR_LEN
//  WAIT_CYCLES    4   idle cycles inserted before each line transfer (0 allowed: WAIT skipped)
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset, asynchronous, active-low (parent drives memory rst with ~rst)
//  rd_req        in   1      line read request, level, held until gnt
//  rd_line_addr  in   LA     line address for read
//  wr_req        in   1      line write request, level, held until gnt
//  wr_line_addr  in   LA     line address for write
//  wr_line       in   32*W   line to write; word i at [32*i+:32]
//  rd_line       out  32*W   line read; word i at [32*i+:32]
//  gnt           out  1      one-cycle pulse: transaction complete
//  mem_addr      out  ADDR_LEN  word address to memory = {line_addr, word_cnt}
//  mem_wr_req    out  1      memory write enable
//  mem_wr_data   out  32     memory write data
//  mem_rd_data   in   32     memory read data (valid 1 cycle after mem_addr)
// BEHAVIOUR
//  - Reset (rst=0, any time): state IDLE, gnt=0, rd_line=0, counters=0, mem_wr_req=0, mem_addr=0.
//    Reset mid-transfer aborts; words already written stay in memory; no gnt issued.
//  - States: IDLE -> WAIT -> WR_XFER | RD_XFER -> DONE -> IDLE.
//  - IDLE: on edge with wr_req=1, latch wr_line_addr and wr_line, op=WRITE; else if rd_req=1, latch
//    rd_line_addr, op=READ. wr_req has priority when both high (write-back before refill); the read
//    stays pending and is accepted in a later IDLE cycle. Goto WAIT (or XFER if WAIT_CYCLES=0).
//  - WAIT: counter runs 0..WAIT_CYCLES-1, then XFER. mem outputs inactive (mem_wr_req=0).
//  - WR_XFER: W cycles, cnt=0..W-1: mem_addr={line,cnt}, mem_wr_req=1, mem_wr_data=latched word cnt.
//  - RD_XFER: W+1 cycles, cnt=0..W: for cnt<W drive mem_addr={line,cnt}; for cnt>=1 capture
//    mem_rd_data into rd_line word cnt-1. mem_wr_req=0 throughout.
//  - DONE: gnt=1 for exactly one cycle, then IDLE. Requester must drop req on the edge that samples gnt;
//    IDLE after DONE re-samples requests (back-to-back transactions allowed, 1 idle cycle between).
//  - Latency: gnt high in cycle after edge WAIT_CYCLES+W (write) / WAIT_CYCLES+W+1 (read), counting the
//    accept edge as 0. Defaults: 12 / 13.
//  - rd_line holds last read line until the next read overwrites it (words update during RD_XFER);
//    write transactions never change rd_line. Only valid for consumption while gnt=1 after a read.
//  - mem_addr/mem_wr_req/mem_wr_data are decoded from registered state/cnt/latched data; 0 outside XFER.
//  - cnt is LINE_ADDR_LEN+1 bits; word index never carries into line address (last line: words
//    2040..2047 with defaults, mem_addr never exceeds 2^ADDR_LEN-1).
//  - Request inputs changing while not IDLE are ignored (addresses/data already latched).
// TESTING (defaults; memory preloaded with the standard lab image)
//  1 After reset, rd_req line 0 -> gnt 13 edges after accept; rd_line words 0..7 =
//    9d,87,83,3a,13,48,6a,ff; line 1 -> 34,5f,05,4f,ef,b1,98,c1.
//  2 wr_req line 2 with words 0x1000_0000+i -> gnt at 12 edges, mem_wr_req high exactly 8 cycles,
//    mem_addr 16..23; then rd_req line 2 -> rd_line reads back 0x1000_0000+i.
//  3 rd_req and wr_req both high in IDLE (rd line 0, wr line 5) -> write done first (gnt #1, addr 40..47),
//    then read (gnt #2, rd_line = line 0 data); exactly two gnt pulses.
//  4 rst=0 asserted in RD_XFER cnt=3 -> outputs 0 immediately, no gnt; after release a new read of
//    line 0 completes normally with correct data.
//  5 rd_req line 255 -> mem_addr 2040..2047 only, rd_line = memory words 2040..2047, no wrap to 0.
//  6 WAIT_CYCLES=0 build: read gnt 9 edges after accept, write gnt 8; rd_req held steady through DONE
//    -> no duplicate accept (requester drops req on gnt edge).

Source files
------------

// File: rtl/line_mem_ctrl_if.sv
// Bundle between the line requester, the burst controller and the word-wide memory.
// The controller takes the slave view; the requester/memory environment takes the master view.
interface line_mem_ctrl_if #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_LEN      = 11
) ();
    localparam int unsigned W  = 1 << LINE_ADDR_LEN;
    localparam int unsigned LA = ADDR_LEN - LINE_ADDR_LEN;

    logic                rd_req;
    logic [LA-1:0]       rd_line_addr;
    logic                wr_req;
    logic [LA-1:0]       wr_line_addr;
    logic [32*W-1:0]     wr_line;
    logic [32*W-1:0]     rd_line;
    logic                gnt;
    logic [ADDR_LEN-1:0] mem_addr;
    logic                mem_wr_req;
    logic [31:0]         mem_wr_data;
    logic [31:0]         mem_rd_data;

    modport master (
        output rd_req, rd_line_addr, wr_req, wr_line_addr, wr_line, mem_rd_data,
        input  rd_line, gnt, mem_addr, mem_wr_req, mem_wr_data
    );

    modport slave (
        input  rd_req, rd_line_addr, wr_req, wr_line_addr, wr_line, mem_rd_data,
        output rd_line, gnt, mem_addr, mem_wr_req, mem_wr_data
    );
endinterface

// File: rtl/line_mem_ctrl.sv
// Cache-line burst controller: turns whole-line read/write requests into per-word memory
// cycles after a programmable access delay, then pulses gnt for one cycle.
module line_mem_ctrl #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_LEN      = 11,
    parameter int unsigned WAIT_CYCLES   = 4
) (
    input logic            clk,
    input logic            rst,
    line_mem_ctrl_if.slave bus
);
    localparam int unsigned W   = 1 << LINE_ADDR_LEN;
    localparam int unsigned LA  = ADDR_LEN - LINE_ADDR_LEN;
    localparam int unsigned WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned CW  = LINE_ADDR_LEN + 1;

    localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [CW-1:0]  WR_LAST   = CW'(W - 1);
    localparam logic [CW-1:0]  RD_LAST   = CW'(W);

    typedef enum logic [2:0] {StIdle, StWait, StWrXfer, StRdXfer, StDone} state_e;

    state_e                 state_q, state_d;
    logic   [CW-1:0]        cnt_q, cnt_d;
    logic   [WCW-1:0]       wait_q, wait_d;
    logic                   op_wr_q, op_wr_d;
    logic   [LA-1:0]        line_q, line_d;
    logic   [32*W-1:0]      wdata_q, wdata_d;
    logic   [32*W-1:0]      rd_line_q, rd_line_d;
    logic   [LINE_ADDR_LEN-1:0] rd_widx;

    // Read data trails the address by one cycle, so cnt addresses word cnt and captures cnt-1.
    assign rd_widx = cnt_q[LINE_ADDR_LEN-1:0] - 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        op_wr_d   = op_wr_q;
        line_d    = line_q;
        wdata_d   = wdata_q;
        rd_line_d = rd_line_q;

        bus.gnt         = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_req  = 1'b0;
        bus.mem_wr_data = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.wr_req) begin
                    op_wr_d = 1'b1;
                    line_d  = bus.wr_line_addr;
                    wdata_d = bus.wr_line;
                    cnt_d   = '0;
                    wait_d  = '0;
                    state_d = (WAIT_CYCLES == 0) ? StWrXfer : StWait;
                end else if (bus.rd_req) begin
                    op_wr_d = 1'b0;
                    line_d  = bus.rd_line_addr;
                    cnt_d   = '0;
                    wait_d  = '0;
                    state_d = (WAIT_CYCLES == 0) ? StRdXfer : StWait;
                end
            end
            StWait: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = op_wr_q ? StWrXfer : StRdXfer;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWrXfer: begin
                bus.mem_addr    = {line_q, cnt_q[LINE_ADDR_LEN-1:0]};
                bus.mem_wr_req  = 1'b1;
                bus.mem_wr_data = wdata_q[{cnt_q[LINE_ADDR_LEN-1:0], 5'b0} +: 32];
                if (cnt_q == WR_LAST) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRdXfer: begin
                if (!cnt_q[LINE_ADDR_LEN]) begin
                    bus.mem_addr = {line_q, cnt_q[LINE_ADDR_LEN-1:0]};
                end
                if (cnt_q != '0) begin
                    rd_line_d[{rd_widx, 5'b0} +: 32] = bus.mem_rd_data;
                end
                if (cnt_q == RD_LAST) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                bus.gnt = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wait_q    <= '0;
            op_wr_q   <= 1'b0;
            line_q    <= '0;
            wdata_q   <= '0;
            rd_line_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            op_wr_q   <= op_wr_d;
            line_q    <= line_d;
            wdata_q   <= wdata_d;
            rd_line_q <= rd_line_d;
        end
    end

    assign bus.rd_line = rd_line_q;
endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: a default-delay instance and a zero-delay instance, each with its
// own word memory model, driven by a vector table plus hand-written corner-case sequences.
module tb_line_mem_ctrl;
    localparam logic [255:0] LINE0 =
        256'h000000ff_0000006a_00000048_00000013_0000003a_00000083_00000087_0000009d;
    localparam logic [255:0] LINE1 =
        256'h000000c1_00000098_000000b1_000000ef_0000004f_00000005_0000005f_00000034;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic preload = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    line_mem_ctrl_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(11)) ifa ();
    line_mem_ctrl_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(11)) ifb ();

    line_mem_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(11), .WAIT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    line_mem_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(11), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    function automatic logic [31:0] img(input int a);
        logic [31:0] lab [16];
        lab = '{32'h9d, 32'h87, 32'h83, 32'h3a, 32'h13, 32'h48, 32'h6a, 32'hff,
                32'h34, 32'h5f, 32'h05, 32'h4f, 32'hef, 32'hb1, 32'h98, 32'hc1};
        if (a < 16) return lab[a];
        return {16'hc0de, a[15:0]};
    endfunction

    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = base + 32'(i);
        return r;
    endfunction

    // Word memories: 1-cycle synchronous read, write on the edge when mem_wr_req is high.
    logic [31:0] mem_a [2048];
    logic [31:0] mem_b [2048];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) begin
                mem_a[i] <= img(i);
                mem_b[i] <= img(i);
            end
        end else begin
            if (ifa.mem_wr_req) mem_a[ifa.mem_addr] <= ifa.mem_wr_data;
            if (ifb.mem_wr_req) mem_b[ifb.mem_addr] <= ifb.mem_wr_data;
        end
        ifa.mem_rd_data <= mem_a[ifa.mem_addr];
        ifb.mem_rd_data <= mem_b[ifb.mem_addr];
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit wr, input bit rd, input logic [7:0] line,
                         input logic [255:0] data);
        if (sel) begin
            ifb.wr_req = wr; ifb.rd_req = rd;
            ifb.wr_line_addr = line; ifb.rd_line_addr = line; ifb.wr_line = data;
        end else begin
            ifa.wr_req = wr; ifa.rd_req = rd;
            ifa.wr_line_addr = line; ifa.rd_line_addr = line; ifa.wr_line = data;
        end
    endtask

    // One line transaction; k counts cycles after the accept edge (edge 0).
    task automatic txn(input bit sel, input bit op, input logic [7:0] line,
                       input logic [255:0] data, input bit hold, output int lat,
                       output logic [255:0] rdl, output int wr_cyc, output int wr_bad,
                       output int hits, output int bad);
        logic g, we;
        logic [10:0] a;
        logic [31:0] wd;
        lat = -1; rdl = '0; wr_cyc = 0; wr_bad = 0; hits = 0; bad = 0;
        @(negedge clk);
        drive(sel, op, !op, line, data);
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            #1;
            g  = sel ? ifb.gnt : ifa.gnt;
            we = sel ? ifb.mem_wr_req : ifa.mem_wr_req;
            a  = sel ? ifb.mem_addr : ifa.mem_addr;
            wd = sel ? ifb.mem_wr_data : ifa.mem_wr_data;
            if (we) begin
                if (wr_cyc >= 8 || a != {line, wr_cyc[2:0]} || wd != data[32*wr_cyc +: 32])
                    wr_bad++;
                wr_cyc++;
            end
            if (a != '0) begin
                if (a[10:3] == line) hits++;
                else bad++;
            end
            if (g) begin
                lat = k;
                rdl = sel ? ifb.rd_line : ifa.rd_line;
                if (!hold) drive(sel, 0, 0, line, data);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
        end
        drive(sel, 0, 0, line, data);
    endtask

    typedef struct {
        bit           op;
        logic [7:0]   line;
        logic [255:0] data;
        int           lat;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [8];
        int lat, wr_cyc, wr_bad, hits, bad, gc, widx, wbad;
        logic [255:0] rdl, last_rd, rl;

        vt[0] = '{1'b0, 8'd0,   LINE0,              13};
        vt[1] = '{1'b0, 8'd1,   LINE1,              13};
        vt[2] = '{1'b1, 8'd2,   mk(32'h1000_0000),  12};
        vt[3] = '{1'b0, 8'd2,   mk(32'h1000_0000),  13};
        vt[4] = '{1'b1, 8'd7,   mk(32'habcd_0000),  12};
        vt[5] = '{1'b0, 8'd7,   mk(32'habcd_0000),  13};
        vt[6] = '{1'b0, 8'd100, mk(32'hc0de_0320),  13};
        vt[7] = '{1'b0, 8'd255, mk(32'hc0de_07f8),  13};

        drive(0, 0, 0, 8'd0, '0);
        drive(1, 0, 0, 8'd0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_gnt", ifa.gnt, 0);
        check("reset_mem_addr", ifa.mem_addr, 0);
        check("reset_mem_wr_req", ifa.mem_wr_req, 0);
        check("reset_rd_line", ifa.rd_line, 0);
        check("reset_gnt_b", ifb.gnt, 0);
        preload = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        last_rd = '0;
        for (int i = 0; i < 8; i++) begin
            txn(0, vt[i].op, vt[i].line, vt[i].data, 0, lat, rdl, wr_cyc, wr_bad, hits, bad);
            check($sformatf("v%0d_latency", i), lat, vt[i].lat);
            check($sformatf("v%0d_addr_hits", i), hits, (vt[i].line == 0) ? 7 : 8);
            check($sformatf("v%0d_addr_stray", i), bad, 0);
            if (vt[i].op) begin
                check($sformatf("v%0d_wr_cycles", i), wr_cyc, 8);
                check($sformatf("v%0d_wr_addr_data", i), wr_bad, 0);
                check($sformatf("v%0d_rd_line_kept", i), rdl, last_rd);
            end else begin
                check($sformatf("v%0d_wr_cycles", i), wr_cyc, 0);
                check($sformatf("v%0d_rd_line", i), rdl, vt[i].data);
                last_rd = vt[i].data;
            end
        end

        // Simultaneous requests: write-back first, then the pending refill.
        @(negedge clk);
        ifa.wr_req = 1'b1; ifa.wr_line_addr = 8'd5; ifa.wr_line = mk(32'h5555_0000);
        ifa.rd_req = 1'b1; ifa.rd_line_addr = 8'd0;
        gc = 0; widx = 0; wbad = 0; rl = '0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (ifa.mem_wr_req) begin
                if (gc != 0 || ifa.mem_addr != 11'(40 + widx)) wbad++;
                widx++;
            end
            if (ifa.gnt) begin
                gc++;
                if (gc == 1) ifa.wr_req = 1'b0;
                else begin
                    rl = ifa.rd_line;
                    ifa.rd_req = 1'b0;
                end
            end
        end
        check("both_gnt_count", gc, 2);
        check("both_wr_cycles", widx, 8);
        check("both_wr_first_addr", wbad, 0);
        check("both_rd_line", rl, LINE0);

        // Reset in RD_XFER with cnt=3 (edge 7 after accept).
        @(negedge clk);
        drive(0, 0, 1, 8'd0, '0);
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        check("abort_pre_addr", ifa.mem_addr, 3);
        rst = 1'b0;
        #1;
        check("abort_gnt", ifa.gnt, 0);
        check("abort_mem_addr", ifa.mem_addr, 0);
        check("abort_mem_wr_req", ifa.mem_wr_req, 0);
        check("abort_rd_line", ifa.rd_line, 0);
        drive(0, 0, 0, 8'd0, '0);
        gc = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                @(negedge clk);
                rst = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ifa.gnt) gc++;
        end
        check("abort_no_gnt", gc, 0);
        txn(0, 0, 8'd0, '0, 0, lat, rdl, wr_cyc, wr_bad, hits, bad);
        check("after_abort_latency", lat, 13);
        check("after_abort_rd_line", rdl, LINE0);

        // Zero-delay instance, requests held through the gnt cycle.
        txn(1, 0, 8'd1, '0, 1, lat, rdl, wr_cyc, wr_bad, hits, bad);
        check("nowait_rd_latency", lat, 9);
        check("nowait_rd_line", rdl, LINE1);
        gc = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (ifb.gnt) gc++;
        end
        check("nowait_no_dup_gnt", gc, 0);
        txn(1, 1, 8'd3, mk(32'h7777_0000), 1, lat, rdl, wr_cyc, wr_bad, hits, bad);
        check("nowait_wr_latency", lat, 8);
        check("nowait_wr_cycles", wr_cyc, 8);
        check("nowait_wr_addr_data", wr_bad, 0);
        txn(1, 0, 8'd3, '0, 1, lat, rdl, wr_cyc, wr_bad, hits, bad);
        check("nowait_rdback_latency", lat, 9);
        check("nowait_rdback_line", rdl, mk(32'h7777_0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
